// File: rtl/serial_frame_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_frame_pkg
// Purpose  : Shared types and constants for the serial frame receiver.
//            Holds the FSM state encoding, the serial direction codes,
//            the start/stop line levels and the default data width.
// Revision : 1.0 - initial release
// ============================================================================
package serial_frame_pkg;

  localparam int DEFAULT_WIDTH = 8;

  // DIR input encoding; matches the transmitter's SHIFT modes.
  localparam logic DIR_MSB_FIRST = 1'b0;
  localparam logic DIR_LSB_FIRST = 1'b1;

  // Line levels of the framing bits. The idle line sits at STOP_BIT.
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_DATA      = 3'd1,
    ST_PARITY    = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_IDLE = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/serial_frame_rx_if.sv
`default_nettype none
// ============================================================================
// Module   : serial_frame_rx_if
// Purpose  : One-entry valid/ready output bus of the serial frame receiver.
// Signals  : DATA  [N] received word
//            VALID [1] DATA holds an unconsumed word
//            READY [1] downstream accepts DATA
// Modports : master - receiver side (drives DATA/VALID)
//            slave  - consumer side (drives READY)
// Revision : 1.0 - initial release
// ============================================================================
interface serial_frame_rx_if
  import serial_frame_pkg::*;
#(
  parameter int N = DEFAULT_WIDTH
) ();

  logic [N-1:0] DATA;
  logic         VALID;
  logic         READY;

  modport master (output DATA, output VALID, input READY);
  modport slave  (input DATA, input VALID, output READY);

endinterface
`default_nettype wire

// File: rtl/serial_frame_rx_shift.sv
`default_nettype none
// ============================================================================
// Module   : rx_shift_reg
// Purpose  : N-bit bidirectional shift register, the receive-side mirror of
//            the transmitter's shift datapath.
// Ports    : CLOCK    in  1  clock
//            RESET    in  1  synchronous active-high reset (clears q)
//            shift_en in  1  shift one bit in this cycle
//            dir      in  1  DIR_MSB_FIRST: enter at bit 0, move left
//                            DIR_LSB_FIRST: enter at bit N-1, move right
//            s_in     in  1  serial bit
//            q        out N  register contents
// Revision : 1.0 - initial release
// ============================================================================
module rx_shift_reg
  import serial_frame_pkg::*;
#(
  parameter int N = DEFAULT_WIDTH
) (
  input  wire logic         CLOCK,
  input  wire logic         RESET,
  input  wire logic         shift_en,
  input  wire logic         dir,
  input  wire logic         s_in,
  output      logic [N-1:0] q
);

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      q <= '0;
    end else if (shift_en) begin
      if (dir == DIR_MSB_FIRST) begin
        q <= {q[N-2:0], s_in};
      end else begin
        q <= {s_in, q[N-1:1]};
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/serial_frame_rx.sv
`default_nettype none
// ============================================================================
// Module   : serial_frame_rx
// Purpose  : Framed serial receiver. Samples one bit per ENABLE-qualified
//            clock edge (start 0, N data bits, optional even parity, stop 1),
//            rebuilds the word and offers it on a one-entry valid/ready
//            buffer. Errors are reported on sticky flags cleared by CLR_ERR.
// Ports    : CLOCK     in  1  clock, rising edge
//            RESET     in  1  synchronous active-high reset
//            ENABLE    in  1  bit strobe; FSM/shifter advance only when 1
//            S_IN      in  1  serial line, idles high
//            DIR       in  1  0 = MSB first, 1 = LSB first (latched at start)
//            CLR_ERR   in  1  clears the sticky flags
//            bus       if     master side: DATA/VALID out, READY in
//            FRAME_ERR out 1  sticky, stop bit sampled low
//            OVERRUN   out 1  sticky, good frame dropped on full buffer
//            PAR_ERR   out 1  sticky, parity mismatch (0 without parity)
// Config   : define SERIAL_FRAME_RX_PARITY_EN to insert an even-parity bit
//            between the data bits and the stop bit.
// Revision : 1.0 - initial release
// ============================================================================
module serial_frame_rx
  import serial_frame_pkg::*;
#(
  parameter int N = DEFAULT_WIDTH
) (
  input  wire logic            CLOCK,
  input  wire logic            RESET,
  input  wire logic            ENABLE,
  input  wire logic            S_IN,
  input  wire logic            DIR,
  input  wire logic            CLR_ERR,
  serial_frame_rx_if.master    bus,
  output      logic            FRAME_ERR,
  output      logic            OVERRUN,
  output      logic            PAR_ERR
);

  localparam int CNT_W = $clog2(N + 1);

  state_t             r_state;
  state_t             w_next;
  logic [CNT_W-1:0]   r_count;
  logic               r_dir_q;
  logic [N-1:0]       w_sh;
  logic [N-1:0]       r_data;
  logic               r_valid;
  logic               r_frame_err;
  logic               r_overrun;

  logic               w_last_bit;
  logic               w_start;
  logic               w_shift_en;
  logic               w_good_frame;
  logic               w_frame_err_set;
  logic               w_par_err_set;
  logic               w_frame_bad;
  logic               w_load;
  logic               w_overrun_set;

  assign w_last_bit = (r_count == CNT_W'(N - 1));

  rx_shift_reg #(.N(N)) u_shift (
    .CLOCK    (CLOCK),
    .RESET    (RESET),
    .shift_en (w_shift_en),
    .dir      (r_dir_q),
    .s_in     (S_IN),
    .q        (w_sh)
  );

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state; nothing moves on cycles without ENABLE
  // --------------------------------------------------------------------------
  always_comb begin
    w_next = r_state;
    if (ENABLE) begin
      case (r_state)
        ST_IDLE: begin
          if (S_IN == START_BIT) w_next = ST_DATA;
        end
        ST_DATA: begin
          if (w_last_bit) begin
`ifdef SERIAL_FRAME_RX_PARITY_EN
            w_next = ST_PARITY;
`else
            w_next = ST_STOP;
`endif
          end
        end
        ST_PARITY: begin
          w_next = ST_STOP;
        end
        ST_STOP: begin
          // A low stop bit means the line may be in a break; wait for idle
          // before hunting for the next start bit.
          w_next = (S_IN == STOP_BIT) ? ST_IDLE : ST_WAIT_IDLE;
        end
        ST_WAIT_IDLE: begin
          if (S_IN == STOP_BIT) w_next = ST_IDLE;
        end
        default: begin
          w_next = ST_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // FSM: per-cycle decoded actions
  // --------------------------------------------------------------------------
  always_comb begin
    w_start         = 1'b0;
    w_shift_en      = 1'b0;
    w_good_frame    = 1'b0;
    w_frame_err_set = 1'b0;
    w_par_err_set   = 1'b0;
    if (ENABLE) begin
      case (r_state)
        ST_IDLE:   w_start    = (S_IN == START_BIT);
        ST_DATA:   w_shift_en = 1'b1;
        ST_PARITY: w_par_err_set = ^{w_sh, S_IN};
        ST_STOP: begin
          w_good_frame    = (S_IN == STOP_BIT) && !w_frame_bad;
          w_frame_err_set = (S_IN != STOP_BIT);
        end
        default: ;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Bit counter and frame direction
  // --------------------------------------------------------------------------
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      r_count <= '0;
      r_dir_q <= DIR_MSB_FIRST;
    end else if (w_start) begin
      r_count <= '0;
      r_dir_q <= DIR;
    end else if (w_shift_en) begin
      r_count <= r_count + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Parity: remember a mismatch from the parity bit until the stop bit
  // --------------------------------------------------------------------------
`ifdef SERIAL_FRAME_RX_PARITY_EN
  logic r_par_bad;
  logic r_par_err;

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      r_par_bad <= 1'b0;
      r_par_err <= 1'b0;
    end else begin
      if (ENABLE && (r_state == ST_PARITY)) r_par_bad <= w_par_err_set;
      if (w_par_err_set)   r_par_err <= 1'b1;
      else if (CLR_ERR)    r_par_err <= 1'b0;
    end
  end

  assign w_frame_bad = r_par_bad;
  assign PAR_ERR     = r_par_err;
`else
  assign w_frame_bad = 1'b0;
  assign PAR_ERR     = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Output buffer. A word loads when the buffer is empty or is being drained
  // on the same edge; otherwise a good frame is dropped as an overrun.
  // --------------------------------------------------------------------------
  assign w_load        = w_good_frame && !(r_valid && !bus.READY);
  assign w_overrun_set = w_good_frame &&  (r_valid && !bus.READY);

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (w_load) begin
      r_data  <= w_sh;
      r_valid <= 1'b1;
    end else if (r_valid && bus.READY) begin
      r_valid <= 1'b0;
    end
  end

  // Sticky flags: a set on the same edge as CLR_ERR takes priority.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_frame_err_set) r_frame_err <= 1'b1;
      else if (CLR_ERR)    r_frame_err <= 1'b0;
      if (w_overrun_set)   r_overrun   <= 1'b1;
      else if (CLR_ERR)    r_overrun   <= 1'b0;
    end
  end

  assign bus.DATA  = r_data;
  assign bus.VALID = r_valid;
  assign FRAME_ERR = r_frame_err;
  assign OVERRUN   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_serial_frame_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_frame_rx
// Purpose  : Self-checking bench for serial_frame_rx (N = 8). Directed frames
//            push their expected word into a queue; a monitor pops and
//            compares on every VALID&READY transfer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_frame_rx;

  localparam int N = 8;

  logic CLOCK;
  logic RESET;
  logic ENABLE;
  logic S_IN;
  logic DIR;
  logic CLR_ERR;
  logic FRAME_ERR;
  logic OVERRUN;
  logic PAR_ERR;

  int checks = 0;
  int errors = 0;
  logic [N-1:0] expq[$];

  serial_frame_rx_if #(.N(N)) bus ();

  serial_frame_rx #(.N(N)) dut (
    .CLOCK     (CLOCK),
    .RESET     (RESET),
    .ENABLE    (ENABLE),
    .S_IN      (S_IN),
    .DIR       (DIR),
    .CLR_ERR   (CLR_ERR),
    .bus       (bus),
    .FRAME_ERR (FRAME_ERR),
    .OVERRUN   (OVERRUN),
    .PAR_ERR   (PAR_ERR)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: inputs change just after posedge, so at negedge the values seen
  // are the ones the next edge will act on.
  always @(negedge CLOCK) begin
    if (!RESET && bus.VALID === 1'b1 && bus.READY === 1'b1) begin
      checks++;
      if (expq.size() == 0) begin
        errors++;
        $display("FAIL xfer_unexpected: got DATA=0x%0h expected no transfer at %0t", bus.DATA, $time);
      end else begin
        logic [N-1:0] e;
        e = expq.pop_front();
        if (bus.DATA !== e) begin
          errors++;
          $display("FAIL xfer_data: got 0x%0h expected 0x%0h at %0t", bus.DATA, e, $time);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge CLOCK); #1;
    end
  endtask

  // Optional random ENABLE=0 gap, then one enabled bit cycle.
  task automatic drive_bit(input logic b, input logic gaps);
    if (gaps) idle($urandom_range(0, 5));
    ENABLE = 1'b1;
    S_IN   = b;
    @(posedge CLOCK); #1;
    ENABLE = 1'b0;
    S_IN   = 1'b1;
  endtask

  // Full frame. DIR is flipped after the start bit so the frame must rely on
  // the direction latched at the start.
  task automatic send_frame(input logic [N-1:0] d, input logic dir, input logic stop_b,
                            input logic par_flip, input logic rdy_at_stop, input logic gaps);
    logic [N-1:0] w;
    logic         pf;
    w  = d;
    pf = par_flip;
    DIR = dir;
    drive_bit(1'b0, gaps);
    DIR = ~dir;
    for (int i = 0; i < N; i++) drive_bit(dir ? w[i] : w[N-1-i], gaps);
`ifdef SERIAL_FRAME_RX_PARITY_EN
    drive_bit((^w) ^ pf, gaps);
`else
    if (pf) $display("note: parity flip ignored without parity");
`endif
    if (rdy_at_stop) bus.READY = 1'b1;
    drive_bit(stop_b, gaps);
  endtask

  task automatic pulse_clr();
    CLR_ERR = 1'b1;
    @(posedge CLOCK); #1;
    CLR_ERR = 1'b0;
  endtask

  initial begin
    RESET     = 1'b1;
    ENABLE    = 1'b0;
    S_IN      = 1'b1;
    DIR       = 1'b0;
    CLR_ERR   = 1'b0;
    bus.READY = 1'b1;
    idle(3);
    RESET = 1'b0;

    // Reset state
    check("rst_data",      32'(bus.DATA),  32'h0);
    check("rst_valid",     32'(bus.VALID), 32'h0);
    check("rst_frame_err", 32'(FRAME_ERR), 32'h0);
    check("rst_overrun",   32'(OVERRUN),   32'h0);
    check("rst_par_err",   32'(PAR_ERR),   32'h0);

    // MSB-first 0xA5, VALID for exactly one cycle
    expq.push_back(8'hA5);
    send_frame(8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("msb_valid_hi", 32'(bus.VALID), 32'h1);
    check("msb_data",     32'(bus.DATA),  32'hA5);
    idle(1);
    check("msb_valid_lo", 32'(bus.VALID), 32'h0);
    check("msb_no_ferr",  32'(FRAME_ERR), 32'h0);
    check("msb_no_ovr",   32'(OVERRUN),   32'h0);

    // LSB-first 0x3C
    expq.push_back(8'h3C);
    send_frame(8'h3C, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("lsb_data", 32'(bus.DATA), 32'h3C);
    idle(2);

    // Framing error, then a held-low line that must not yield frames
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) drive_bit(1'b0, 1'b0);
    check("ferr_set",   32'(FRAME_ERR), 32'h1);
    check("ferr_valid", 32'(bus.VALID), 32'h0);
    drive_bit(1'b1, 1'b0);
    expq.push_back(8'h5A);
    send_frame(8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("ferr_recover", 32'(bus.DATA), 32'h5A);
    idle(2);
    pulse_clr();
    check("ferr_clr", 32'(FRAME_ERR), 32'h0);

    // Overrun: second back-to-back frame dropped while READY=0
    bus.READY = 1'b0;
    expq.push_back(8'h11);
    send_frame(8'h11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    send_frame(8'h22, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("ovr_set",   32'(OVERRUN),   32'h1);
    check("ovr_data",  32'(bus.DATA),  32'h11);
    check("ovr_valid", 32'(bus.VALID), 32'h1);
    pulse_clr();
    check("ovr_clr",   32'(OVERRUN),   32'h0);
    check("ovr_hold",  32'(bus.DATA),  32'h11);
    // Drain and load on the same edge: no overrun
    expq.push_back(8'h11);
    expq.push_back(8'h33);
    // 0x11 already queued once above; remove the duplicate
    void'(expq.pop_back());
    void'(expq.pop_back());
    expq.push_back(8'h33);
    send_frame(8'h33, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    check("swap_data",  32'(bus.DATA),  32'h33);
    check("swap_valid", 32'(bus.VALID), 32'h1);
    check("swap_no_ovr", 32'(OVERRUN),  32'h0);
    idle(2);

    // ENABLE gaps
    expq.push_back(8'hC3);
    send_frame(8'hC3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    check("gap_data", 32'(bus.DATA), 32'hC3);
    idle(2);

    // Reset mid-frame (start + 4 data bits)
    DIR = 1'b0;
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b1, 1'b0);
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b1, 1'b0);
    drive_bit(1'b1, 1'b0);
    RESET = 1'b1;
    idle(1);
    RESET = 1'b0;
    check("mrst_data",  32'(bus.DATA),  32'h0);
    check("mrst_valid", 32'(bus.VALID), 32'h0);
    check("mrst_flags", 32'({FRAME_ERR, OVERRUN, PAR_ERR}), 32'h0);
    expq.push_back(8'h81);
    send_frame(8'h81, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("post_rst_data", 32'(bus.DATA), 32'h81);
    idle(2);

`ifdef SERIAL_FRAME_RX_PARITY_EN
    expq.push_back(8'h07);
    send_frame(8'h07, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("par_ok_data", 32'(bus.DATA), 32'h07);
    check("par_ok_flag", 32'(PAR_ERR),  32'h0);
    idle(2);
    send_frame(8'h07, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    check("par_bad_flag",  32'(PAR_ERR),   32'h1);
    check("par_bad_valid", 32'(bus.VALID), 32'h0);
`else
    check("par_tied_low", 32'(PAR_ERR), 32'h0);
`endif

    idle(4);
    check("queue_empty", 32'(expq.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got no completion expected finish before 200000");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

endmodule
`default_nettype wire
